sipo_receiver: RTL and testbench

Serial-in, parallel-out frame receiver: the receiving end of the serial link driven by the team's 4-bit universal shift register when it runs in a shift mode. It samples a start/data/stop-framed bitstream on a bit strobe and reassembles WIDTH-bit words, LSB-first or MSB-first. It presents each word on a valid/ready parallel port through a one-word holding buffer, and flags overrun and framing errors.

---
 rtl/sipo_receiver.sv | 123 ++++++++++++
 tb/tb_sipo_receiver.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sipo_receiver.sv
// sipo_receiver: start/data/stop framed serial-in, parallel-out receiver with a one-word valid/ready holding buffer
//
// Optional feature macro: PARITY_EN (adds an even-parity bit after the data bits).
//
// Ports:
//   clk         rising-edge clock
//   clr         asynchronous active-high reset
//   sin         serial line, idle high
//   sin_en      bit strobe; sin is only sampled on edges with sin_en=1
//   dir         0 = LSB first, 1 = MSB first; latched at start-bit detection
//   dout        received word (holding buffer)
//   dout_valid  holding buffer full
//   dout_ready  consumer accepts dout
//   busy        frame in progress
//   overrun     one-cycle pulse: good word dropped because the buffer was full
//   frame_err   one-cycle pulse: stop bit sampled low
//   parity_err  one-cycle pulse: parity mismatch (always 0 without PARITY_EN)
module sipo_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             dir,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  output logic             parity_err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DATA      = 3'd1;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;
  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_overrun;
  logic             r_frame_err;
  logic             w_perr;
  logic             w_good;
  logic             w_load;
  logic [2:0]       w_after_data;
  // A good stop bit loads the buffer when it is empty or being drained on this same edge.
  assign w_good = sin_en & (r_state == S_STOP) & sin & ~w_perr;
  assign w_load = w_good & (~r_valid | dout_ready);
`ifdef PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd2;
  logic r_perr;
  logic r_parity_err;
  logic w_par_bad;
  // Even parity over data plus parity bit: any odd total is a mismatch.
  assign w_par_bad    = (^r_sh) ^ sin;
  assign w_after_data = S_PARITY;
  assign w_perr       = r_perr;
  assign parity_err   = r_parity_err;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_perr       <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= sin_en & (r_state == S_PARITY) & w_par_bad;
      if (sin_en && r_state == S_IDLE && !sin) r_perr <= 1'b0;
      else if (sin_en && r_state == S_PARITY) r_perr <= w_par_bad;
    end
  end
`else
  assign w_after_data = S_STOP;
  assign w_perr       = 1'b0;
  assign parity_err   = 1'b0;
`endif
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_dir       <= 1'b0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= w_good & r_valid & ~dout_ready;
      r_frame_err <= sin_en & (r_state == S_STOP) & ~sin;
      r_valid     <= w_load | (r_valid & ~dout_ready);
      if (w_load) r_dout <= r_sh;
      if (sin_en) begin
        case (r_state)
          S_IDLE: if (!sin) begin
            r_dir   <= dir;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_state <= S_DATA;
          end
          S_DATA: begin
            r_sh  <= r_dir ? {r_sh[WIDTH-2:0], sin} : {sin, r_sh[WIDTH-1:1]};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) r_state <= w_after_data;
          end
`ifdef PARITY_EN
          S_PARITY:    r_state <= S_STOP;
`endif
          S_STOP:      r_state <= sin ? S_IDLE : S_WAIT_HIGH;
          // A held-low line (break) must return high before a new start bit counts.
          S_WAIT_HIGH: if (sin) r_state <= S_IDLE;
          default:     r_state <= S_IDLE;
        endcase
      end
    end
  end
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign busy       = r_state != S_IDLE;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;
endmodule

// File: tb/tb_sipo_receiver.sv
// tb_sipo_receiver: directed and randomized frames checked against a frame-level model of the receiver
module tb_sipo_receiver;
  localparam int W = 4;
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0;
  logic clr, sin, sin_en, dir, dout_ready;
  logic [W-1:0] dout;
  logic dout_valid, busy, overrun, frame_err, parity_err;
  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] exp_dout;
  logic exp_valid;
  always #5 clk = ~clk;
  sipo_receiver #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .sin(sin), .sin_en(sin_en), .dir(dir),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // Idle gap cycles (strobe low, line noise) then one strobed bit; sampled 1 time unit after the edge.
  task automatic strobe(input logic b, input int gap, input logic rdy);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      sin_en = 1'b0;
      sin = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    sin_en = 1'b1;
    sin = b;
    dout_ready = rdy;
    @(posedge clk);
    #1;
    sin_en = 1'b0;
    dout_ready = 1'b0;
  endtask
  task automatic send(input logic [W-1:0] w, input logic d, input logic stop, input logic bad_par,
                      input logic rdy, input int maxgap, input int nz);
    logic good, ovr;
    dir = d;
    strobe(1'b0, $urandom_range(0, maxgap), 1'b0);
    dir = 1'($urandom_range(0, 1));
    chk("busy_start", busy, 1);
    chk("overrun_idle", overrun, 0);
    chk("frame_err_idle", frame_err, 0);
    for (int i = 0; i < W; i++) strobe(d ? w[W-1-i] : w[i], $urandom_range(0, maxgap), 1'b0);
    if (PAR) begin
      strobe((^w) ^ bad_par, $urandom_range(0, maxgap), 1'b0);
      chk("parity_err", parity_err, bad_par);
    end
    strobe(stop, $urandom_range(0, maxgap), rdy);
    good = stop && !(PAR && bad_par);
    ovr = good && exp_valid && !rdy;
    if (good && (!exp_valid || rdy)) begin
      exp_dout = w;
      exp_valid = 1'b1;
    end else if (exp_valid && rdy) exp_valid = 1'b0;
    chk("dout", dout, exp_dout);
    chk("dout_valid", dout_valid, exp_valid);
    chk("overrun", overrun, ovr);
    chk("frame_err", frame_err, !stop);
    chk("parity_err_stop", parity_err, 0);
    chk("busy_stop", busy, !stop);
    if (!stop) begin
      for (int i = 0; i < nz; i++) begin
        strobe(1'b0, $urandom_range(0, maxgap), 1'b0);
        chk("wait_busy", busy, 1);
        chk("wait_frame_err", frame_err, 0);
      end
      strobe(1'b1, $urandom_range(0, maxgap), 1'b0);
      chk("wait_exit_busy", busy, 0);
    end
  endtask
  task automatic consume();
    @(negedge clk);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    exp_valid = 1'b0;
    chk("consume_valid", dout_valid, 0);
    chk("consume_dout", dout, exp_dout);
  endtask
  initial begin
    clr = 1'b1; sin = 1'b1; sin_en = 1'b0; dir = 1'b0; dout_ready = 1'b0;
    exp_dout = '0; exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {overrun, frame_err, parity_err}, 0);
    @(negedge clk);
    clr = 1'b0;
    send(4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    consume();
    send(4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    consume();
    send(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    send(4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    consume();
    send(4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
    send(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    consume();
    send(4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    send(4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
    strobe(1'b0, 0, 1'b0);
    strobe(1'b1, 0, 1'b0);
    strobe(1'b0, 0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_dout", dout, 0);
    chk("clr_valid", dout_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_flags", {overrun, frame_err, parity_err}, 0);
    @(negedge clk);
    clr = 1'b0;
    exp_dout = '0;
    exp_valid = 1'b0;
    send(4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    consume();
    if (PAR) begin
      send(4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      consume();
      send(4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    end
    for (int f = 0; f < 150; f++) begin
      send(W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
           PAR && ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 2, $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) consume();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
